// File: rtl/enemy_spawner_if.sv
// Enemy-state bus between the spawner (master) and the game-state /
// collision logic (slave): hit reports in, per-slot enemy state out.
interface enemy_spawner_if #(
  parameter int N_ENEMY = 8,
  parameter int IW      = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
);
  logic                     hit_valid;
  logic [IW-1:0]            hit_idx;
  logic [N_ENEMY-1:0]       enemy_alive;
  logic [N_ENEMY-1:0][9:0]  enemy_x;
  logic [N_ENEMY-1:0][8:0]  enemy_y;

  modport master (input hit_valid, hit_idx, output enemy_alive, enemy_x, enemy_y);
  modport slave  (output hit_valid, hit_idx, input enemy_alive, enemy_x, enemy_y);
endinterface

// File: rtl/enemy_spawner.sv
// Enemy spawner: owns N_ENEMY slots, spawns at LFSR-chosen columns on a timer,
// walks live enemies down the screen, kills slots on hit reports.
// Frozen outside S_RUN so the game-over screen is stable.
// Optional macro ENEMY_SPEEDUP_EN: move period shrinks with score level.
module enemy_spawner #(
  parameter int          N_ENEMY      = 8,
  parameter int          SPAWN_PERIOD = 25000000,
  parameter int          MOVE_PERIOD  = 500000,
  parameter int          STEP         = 1,
  parameter int          Y_MAX        = 479,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  gameover,
  enemy_spawner_if.master       bus,
  output logic [15:0]           score,
  output logic                  running
);
  localparam int MW = $clog2(MOVE_PERIOD + 1);
  localparam int SW = $clog2(SPAWN_PERIOD + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state, state_nx;
  logic [15:0]             lfsr, lfsr_nx;
  logic [MW-1:0]           mv_cnt, mv_nx;
  logic [SW-1:0]           sp_cnt, sp_nx;
  logic [N_ENEMY-1:0]      alive, alive_nx;
  logic [N_ENEMY-1:0][9:0] xs, xs_nx;
  logic [N_ENEMY-1:0][8:0] ys, ys_nx;
  logic [15:0]             score_nx;
  int                      eff_period;
  logic                    mv_wrap, sp_wrap, hit_ok, found;
  logic [4:0]              col;
  logic [9:0]              ysum;

  assign bus.enemy_alive = alive;
  assign bus.enemy_x     = xs;
  assign bus.enemy_y     = ys;

`ifdef ENEMY_SPEEDUP_EN
  logic [1:0] level;
  // Speed level from kill count: every 16 kills halves the move period, up to 3 times.
  always_comb begin
    level      = (score[15:4] >= 12'd3) ? 2'd3 : score[5:4];
    eff_period = MOVE_PERIOD >> level;
    if (eff_period < 1) eff_period = 1;
  end
`else
  assign eff_period = MOVE_PERIOD;
`endif

  // Free-running 16-bit Galois LFSR, taps 16'hB400.
  assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state: start only matters in idle, gameover only while running.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start)    state_nx = S_RUN;
      S_RUN:  if (gameover) state_nx = S_IDLE;
      default:              state_nx = S_IDLE;
    endcase
  end

  // Slot/score/counter update; all decisions use pre-edge alive bits.
  always_comb begin
    alive_nx = alive;
    xs_nx    = xs;
    ys_nx    = ys;
    score_nx = score;
    mv_nx    = mv_cnt;
    sp_nx    = sp_cnt;
    mv_wrap  = (int'(mv_cnt) >= eff_period - 1);
    sp_wrap  = (int'(sp_cnt) >= SPAWN_PERIOD - 1);
    hit_ok   = bus.hit_valid && (int'(bus.hit_idx) < N_ENEMY) && alive[bus.hit_idx];
    col      = (lfsr[4:0] < 5'd20) ? lfsr[4:0] : lfsr[4:0] - 5'd12;
    ysum     = '0;
    found    = 1'b0;
    if (state == S_IDLE && start) begin
      alive_nx = '0;
      xs_nx    = '0;
      ys_nx    = '0;
      score_nx = '0;
      mv_nx    = '0;
      sp_nx    = '0;
    end else if (state == S_RUN && !gameover) begin
      mv_nx = mv_wrap ? '0 : mv_cnt + MW'(1);
      sp_nx = sp_wrap ? '0 : sp_cnt + SW'(1);
      if (mv_wrap) begin
        for (int i = 0; i < N_ENEMY; i++) begin
          if (alive[i]) begin
            ysum     = {1'b0, ys[i]} + 10'(STEP);
            ys_nx[i] = (ysum > 10'(Y_MAX)) ? 9'(Y_MAX) : ysum[8:0];
          end
        end
      end
      // Spawn into the lowest-index dead slot; overrides any same-cycle move.
      if (sp_wrap) begin
        for (int i = 0; i < N_ENEMY; i++) begin
          if (!alive[i] && !found) begin
            found       = 1'b1;
            alive_nx[i] = 1'b1;
            xs_nx[i]    = {col, 5'b0};
            ys_nx[i]    = '0;
          end
        end
      end
      if (hit_ok) begin
        alive_nx[bus.hit_idx] = 1'b0;
        if (score != 16'hFFFF) score_nx = score + 16'd1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr    <= LFSR_SEED;
      mv_cnt  <= '0;
      sp_cnt  <= '0;
      alive   <= '0;
      xs      <= '0;
      ys      <= '0;
      score   <= '0;
      running <= 1'b0;
    end else begin
      lfsr    <= lfsr_nx;
      mv_cnt  <= mv_nx;
      sp_cnt  <= sp_nx;
      alive   <= alive_nx;
      xs      <= xs_nx;
      ys      <= ys_nx;
      score   <= score_nx;
      running <= (state_nx == S_RUN);
    end
  end
endmodule

// File: tb/tb_enemy_spawner.sv
// Randomized bench for enemy_spawner: two instances (unit step, and STEP=3 /
// Y_MAX=10 for saturation) driven identically and compared every cycle
// against a per-instance reference model of the game rules.
module tb_enemy_spawner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic gameover = 1'b0;
  logic [15:0] score0, score1;
  logic running0, running1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  enemy_spawner_if #(.N_ENEMY(4)) bus0 ();
  enemy_spawner_if #(.N_ENEMY(4)) bus1 ();

  enemy_spawner #(.N_ENEMY(4), .SPAWN_PERIOD(10), .MOVE_PERIOD(4), .STEP(1), .Y_MAX(479))
    u_dut0 (.clk(clk), .reset(reset), .start(start), .gameover(gameover),
            .bus(bus0), .score(score0), .running(running0));
  enemy_spawner #(.N_ENEMY(4), .SPAWN_PERIOD(10), .MOVE_PERIOD(4), .STEP(3), .Y_MAX(10))
    u_dut1 (.clk(clk), .reset(reset), .start(start), .gameover(gameover),
            .bus(bus1), .score(score1), .running(running1));

  // Reference model state, one row per instance.
  int          m_run[2];
  int          m_alive[2][4];
  int          m_x[2][4];
  int          m_y[2][4];
  int          m_score[2];
  int          m_mc[2];
  int          m_sc[2];
  logic [15:0] m_lfsr[2];

  function automatic int p_step(input int d);
    return (d == 0) ? 1 : 3;
  endfunction
  function automatic int p_ymax(input int d);
    return (d == 0) ? 479 : 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_run[d] = 0; m_score[d] = 0; m_mc[d] = 0; m_sc[d] = 0; m_lfsr[d] = 16'hACE1;
    for (int i = 0; i < 4; i++) begin m_alive[d][i] = 0; m_x[d][i] = 0; m_y[d][i] = 0; end
  endtask

  // One clock of game rules, evaluated from the state before the edge.
  task automatic model_step(input int d, input logic st, input logic go, input logic hv, input int hi);
    int old_alive[4];
    int period, lvl, c, tgt;
    bit mv, sp;
    for (int i = 0; i < 4; i++) old_alive[i] = m_alive[d][i];
    if (m_run[d] == 0) begin
      if (st) begin
        m_run[d] = 1; m_score[d] = 0; m_mc[d] = 0; m_sc[d] = 0;
        for (int i = 0; i < 4; i++) begin m_alive[d][i] = 0; m_x[d][i] = 0; m_y[d][i] = 0; end
      end
    end else if (go) begin
      m_run[d] = 0;
    end else begin
      period = 4;
`ifdef ENEMY_SPEEDUP_EN
      lvl = m_score[d] / 16;
      if (lvl > 3) lvl = 3;
      period = 4 >> lvl;
      if (period < 1) period = 1;
`else
      lvl = 0;
`endif
      mv = (m_mc[d] >= period - 1);
      sp = (m_sc[d] == 9);
      m_mc[d] = mv ? 0 : m_mc[d] + 1;
      m_sc[d] = sp ? 0 : m_sc[d] + 1;
      if (mv)
        for (int i = 0; i < 4; i++)
          if (old_alive[i] != 0) begin
            m_y[d][i] = m_y[d][i] + p_step(d);
            if (m_y[d][i] > p_ymax(d)) m_y[d][i] = p_ymax(d);
          end
      if (sp) begin
        tgt = -1;
        for (int i = 3; i >= 0; i--) if (old_alive[i] == 0) tgt = i;
        if (tgt >= 0) begin
          c = int'(m_lfsr[d] & 16'h1F);
          if (c >= 20) c = c - 12;
          m_alive[d][tgt] = 1; m_x[d][tgt] = c * 32; m_y[d][tgt] = 0;
        end
      end
      if (hv && old_alive[hi] != 0) begin
        m_alive[d][hi] = 0;
        if (m_score[d] < 65535) m_score[d] = m_score[d] + 1;
      end
    end
    m_lfsr[d] = m_lfsr[d][0] ? ((m_lfsr[d] >> 1) ^ 16'hB400) : (m_lfsr[d] >> 1);
  endtask

  task automatic check_dut(input int d);
    logic [3:0]       a;
    logic [3:0][9:0]  xs;
    logic [3:0][8:0]  ys;
    logic [15:0]      sc;
    logic             rn;
    logic [3:0]       ea;
    if (d == 0) begin a = bus0.enemy_alive; xs = bus0.enemy_x; ys = bus0.enemy_y; sc = score0; rn = running0; end
    else        begin a = bus1.enemy_alive; xs = bus1.enemy_x; ys = bus1.enemy_y; sc = score1; rn = running1; end
    for (int i = 0; i < 4; i++) ea[i] = (m_alive[d][i] != 0);
    chk($sformatf("d%0d.running", d), 32'(rn), 32'(m_run[d]));
    chk($sformatf("d%0d.score", d), 32'(sc), 32'(m_score[d]));
    chk($sformatf("d%0d.alive", d), 32'(a), 32'(ea));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d.x%0d", d, i), 32'(xs[i]), 32'(m_x[d][i]));
      chk($sformatf("d%0d.y%0d", d, i), 32'(ys[i]), 32'(m_y[d][i]));
    end
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare 1ns later.
  task automatic cycle(input logic st, input logic go, input logic hv, input logic [1:0] hi);
    start = st; gameover = go;
    bus0.hit_valid = hv; bus0.hit_idx = hi;
    bus1.hit_valid = hv; bus1.hit_idx = hi;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!reset) model_reset(d);
      else        model_step(d, st, go, hv, int'(hi));
    end
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++)
      cycle(($urandom % 8) == 0, ($urandom % 80) == 0, ($urandom % 4) == 0, 2'($urandom));
  endtask

  initial begin
    bus0.hit_valid = 1'b0; bus0.hit_idx = '0;
    bus1.hit_valid = 1'b0; bus1.hit_idx = '0;
    for (int d = 0; d < 2; d++) model_reset(d);
    #2;
    for (int d = 0; d < 2; d++) check_dut(d);
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    // Idle: inputs other than start have no effect.
    cycle(1'b0, 1'b1, 1'b1, 2'd1);
    cycle(1'b0, 1'b0, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    // Start, then fill all slots with no hits.
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 45; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    // Kill slot 2, hit it again while dead, then let it refill.
    cycle(1'b0, 1'b0, 1'b1, 2'd2);
    cycle(1'b0, 1'b0, 1'b1, 2'd2);
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    // Game over, frozen screen, restart.
    cycle(1'b0, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 100; k++) cycle(1'b0, 1'b0, ($urandom % 3) == 0, 2'($urandom));
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    rand_cycles(900);
    // Asynchronous reset mid-game, between clock edges.
    if (!m_run[0]) cycle(1'b1, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 30; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin model_reset(d); check_dut(d); end
    cycle(1'b1, 1'b0, 1'b1, 2'd0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    rand_cycles(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
